// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-stage control sequencer for the PC multiplexer. Each cycle it picks the
// PC source (sequential, boot vector, interrupt vector, branch/call target),
// decides whether the PC register loads, drives the front-end flush lines and
// walks the boot and interrupt-entry sequences.
//
// Parameters
//   BOOT_WAIT     cycles after reset release before the boot vector loads (1-15)
//   DRAIN_CYCLES  cycles fetch is frozen before interrupt entry (0-15)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   branch_taken  execute stage resolved a taken branch/call/ret
//   hazard_stall  load-use / structural stall, freezes the PC
//   mem_stall     memory busy, freezes the PC and all internal counters
//   irq           external interrupt request (synchronous to clk)
//   rti_done      RTI retired, clears in_isr
//   pc_selection  00 seq, 01 boot vector, 10 interrupt vector, 11 branch target
//   pc_enable     PC register loads this edge
//   flush_fd      squash fetch/decode register
//   flush_de      squash decode/execute register
//   int_ack       one-cycle acknowledge to the interrupt source
//   save_pc_en    capture current sequential PC as return address
//   in_isr        handler active, further irq masked
//
// Build option
//   IRQ_LATCH_EN  when defined, a pending flop captures irq in every state and
//                 holds it until int_ack; otherwise irq is sampled only in RUN.
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int unsigned BOOT_WAIT    = 2,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       branch_taken,
   input  logic       hazard_stall,
   input  logic       mem_stall,
   input  logic       irq,
   input  logic       rti_done,
   output logic [1:0] pc_selection,
   output logic       pc_enable,
   output logic       flush_fd,
   output logic       flush_de,
   output logic       int_ack,
   output logic       save_pc_en,
   output logic       in_isr
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_INT_DRAIN,
      S_INT_ENTER
   } state_e;

   localparam logic [1:0] SEL_SEQ  = 2'b00;
   localparam logic [1:0] SEL_BOOT = 2'b01;
   localparam logic [1:0] SEL_INT  = 2'b10;
   localparam logic [1:0] SEL_BR   = 2'b11;

   localparam logic [3:0] BOOT_WAIT_C    = 4'(BOOT_WAIT);
   localparam logic [3:0] DRAIN_CYCLES_C = 4'(DRAIN_CYCLES);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       in_isr_q, in_isr_d;
   logic       irq_req;
   logic       irq_eligible;

   logic [1:0] sel_c;
   logic       en_c, ffd_c, fde_c, ack_c, save_c;

   // Counters saturate instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

`ifdef IRQ_LATCH_EN
   logic pend_q, pend_d;

   assign irq_req = irq | pend_q;
   assign pend_d  = ack_c ? 1'b0 : (pend_q | irq);
`else
   assign irq_req = irq;
`endif

   assign irq_eligible = irq_req & ~in_isr_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_isr_d = in_isr_q;
      sel_c    = SEL_SEQ;
      en_c     = 1'b0;
      ffd_c    = 1'b0;
      fde_c    = 1'b0;
      ack_c    = 1'b0;
      save_c   = 1'b0;

      unique case (state_q)
         S_BOOT: begin
            ffd_c = 1'b1;
            if (!mem_stall) begin
               if (cnt_q == BOOT_WAIT_C) begin
                  sel_c   = SEL_BOOT;
                  en_c    = 1'b1;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
         end

         S_RUN: begin
            if (mem_stall) begin
               en_c = 1'b0;
            end else if (branch_taken) begin
               sel_c = SEL_BR;
               en_c  = 1'b1;
               ffd_c = 1'b1;
               fde_c = 1'b1;
            end else if (hazard_stall) begin
               en_c = 1'b0;
            end else if (irq_eligible) begin
               cnt_d   = '0;
               state_d = (DRAIN_CYCLES == 0) ? S_INT_ENTER : S_INT_DRAIN;
            end else begin
               sel_c = SEL_SEQ;
               en_c  = 1'b1;
            end
         end

         S_INT_DRAIN: begin
            ffd_c = 1'b1;
            if (!mem_stall) begin
               // A branch resolving mid-drain still redirects the PC so the
               // return address captured at entry is the branch target.
               if (branch_taken) begin
                  sel_c = SEL_BR;
                  en_c  = 1'b1;
                  fde_c = 1'b1;
               end
               if (sat_inc(cnt_q) >= DRAIN_CYCLES_C) begin
                  cnt_d   = '0;
                  state_d = S_INT_ENTER;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
         end

         S_INT_ENTER: begin
            ffd_c = 1'b1;
            if (!mem_stall) begin
               // save_pc_en captures the PC before this edge's vector load.
               sel_c   = SEL_INT;
               en_c    = 1'b1;
               ack_c   = 1'b1;
               save_c  = 1'b1;
               state_d = S_RUN;
            end
         end

         default: begin
            state_d = S_BOOT;
            cnt_d   = '0;
         end
      endcase

      // Entry takes priority over a simultaneous RTI.
      if (rti_done) begin
         in_isr_d = 1'b0;
      end
      if (ack_c) begin
         in_isr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_BOOT;
         cnt_q    <= '0;
         in_isr_q <= 1'b0;
`ifdef IRQ_LATCH_EN
         pend_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         in_isr_q <= in_isr_d;
`ifdef IRQ_LATCH_EN
         pend_q   <= pend_d;
`endif
      end
   end

   // Outputs are combinational from state and inputs; while reset is held
   // they are forced low even though BOOT would otherwise flush.
   assign pc_selection = rst ? sel_c  : '0;
   assign pc_enable    = rst & en_c;
   assign flush_fd     = rst & ffd_c;
   assign flush_de     = rst & fde_c;
   assign int_ack      = rst & ack_c;
   assign save_pc_en   = rst & save_c;
   assign in_isr       = in_isr_q;

endmodule
